// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bit-counter width: log2 of the operand width, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    if (width <= 1) return 1;
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Existing 1-bit full-adder cell used as the shared bit slice.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic Cout
);

  assign sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell, LSB first, WIDTH+2 cycles per op.
// Optional subtract mode (port sub_in) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  full_adder u_fa (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (carry),
    .sum (fa_sum),
    .Cout(fa_cout)
  );

  // Shift-then-overwrite keeps the WIDTH=1 case free of an empty slice.
  always_comb begin
    result_next            = result >> 1;
    result_next[WIDTH-1]   = fa_sum;
  end

  always_comb begin
    b_load     = b_in;
    carry_load = cin_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub_in) begin
      b_load     = ~b_in;
      carry_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      result      <= '0;
      cout        <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh        <= a_in;
            b_sh        <= b_load;
            carry       <= carry_load;
            cnt         <= '0;
            busy        <= 1'b1;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          result <= result_next;
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST) begin
            cout  <= fa_cout;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); subtract tests build with SERIAL_ADDER_SUB_EN.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub_in;
`endif
  logic [W-1:0] result;
  logic         cout;
  logic         done;
  logic         busy;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .cin_in     (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_in     (sub_in),
`endif
    .result     (result),
    .cout       (cout),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: add is a+b+cin in W+1 bits; subtract is (a-b) mod 2^W with cout = no borrow.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    int unsigned ai = a;
    int unsigned bi = b;
    logic [W-1:0] d;
    if (s) begin
      d = W'(ai - bi);
      return {(ai >= bi), d};
    end
    return (W+1)'(ai + bi + int'(c));
  endfunction

  // Performs one accepted operation and reports what the DUT showed; callers do the checking.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output int lat, output logic [W-1:0] r, output logic co,
                        output logic done_after, output logic ready_after,
                        output logic [W-1:0] r_after);
    int waitn = 0;
    @(negedge clk);
    while (!start_ready && waitn < 40) begin
      @(negedge clk);
      waitn++;
    end
    a_in = a; b_in = b; cin_in = c; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= W + 4; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    r  = result;
    co = cout;
    @(posedge clk);
    #1;
    done_after  = done;
    ready_after = start_ready;
    r_after     = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", start_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] r, ra; logic co, da, rdy;
    run_op(8'h35, 8'h4A, 1'b0, lat, r, co, da, rdy, ra);
    checks++; if (lat !== W) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
    checks++; if (r !== 8'h7F) begin errors++; $display("FAIL basic_result: got %h expected 7f", r); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", co); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width: done still %b one cycle later", da); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b expected 1", rdy); end
    checks++; if (ra !== 8'h7F) begin errors++; $display("FAIL basic_result_hold: got %h expected 7f", ra); end
  endtask

  task automatic test_carry();
    int lat; logic [W-1:0] r, ra; logic co, da, rdy;
    run_op(8'hFF, 8'h01, 1'b0, lat, r, co, da, rdy, ra);
    checks++; if ({co, r} !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got %b_%h expected 1_00", co, r); end
    run_op(8'hFF, 8'hFF, 1'b1, lat, r, co, da, rdy, ra);
    checks++; if ({co, r} !== 9'h1FF) begin errors++; $display("FAIL carry_ff_ff_1: got %b_%h expected 1_ff", co, r); end
    checks++; if (lat !== W) begin errors++; $display("FAIL carry_latency: got %0d expected %0d", lat, W); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, r1, r2;
    logic c1, c2, co1, co2, ready_bad;
    logic [W:0] e1, e2;
    int dcount, d1_n, d2_n, waitn;
    a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
    a2 = W'($urandom); b2 = W'($urandom); c2 = 1'($urandom);
    e1 = model(a1, b1, c1, 1'b0);
    e2 = model(a2, b2, c2, 1'b0);
    dcount = 0; d1_n = -1; d2_n = -1; ready_bad = 1'b0; waitn = 0;
    r1 = '0; r2 = '0; co1 = 1'b0; co2 = 1'b0;
    @(negedge clk);
    while (!start_ready && waitn < 40) begin @(negedge clk); waitn++; end
    a_in = a1; b_in = b1; cin_in = c1; start_valid = 1'b1;
    @(posedge clk);
    #1 a_in = a2; b_in = b2; cin_in = c2;
    for (int n = 1; n <= 2 * W + 6; n++) begin
      @(posedge clk);
      #1;
      if (n <= W && start_ready !== 1'b0) ready_bad = 1'b1;
      if (n == W + 2) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy=%b expected 1 at k+%0d", busy, W + 2); end
        start_valid = 1'b0;
      end
      if (done) begin
        dcount++;
        if (dcount == 1) begin d1_n = n; r1 = result; co1 = cout; end
        if (dcount == 2) begin d2_n = n; r2 = result; co2 = cout; end
      end
    end
    checks++; if (ready_bad !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: start_ready seen high during run, expected 0"); end
    checks++; if (dcount !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dcount); end
    checks++; if (d1_n !== W) begin errors++; $display("FAIL b2b_done1_edge: got %0d expected %0d", d1_n, W); end
    checks++; if (d2_n !== 2 * W + 2) begin errors++; $display("FAIL b2b_done2_edge: got %0d expected %0d", d2_n, 2 * W + 2); end
    checks++; if ({co1, r1} !== e1) begin errors++; $display("FAIL b2b_op1: got %b_%h expected %h", co1, r1, e1); end
    checks++; if ({co2, r2} !== e2) begin errors++; $display("FAIL b2b_op2: got %b_%h expected %h", co2, r2, e2); end
  endtask

  task automatic test_abort();
    int lat, dseen, waitn; logic [W-1:0] r, ra, a, b; logic co, da, rdy, c;
    dseen = 0; waitn = 0;
    @(negedge clk);
    while (!start_ready && waitn < 40) begin @(negedge clk); waitn++; end
    a_in = 8'hAA; b_in = 8'h55; cin_in = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({start_ready, busy, done, cout, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
      begin errors++; $display("FAIL abort_outputs: ready=%b busy=%b done=%b cout=%b result=%h expected 1 0 0 0 00",
                               start_ready, busy, done, cout, result); end
    rst = 1'b0;
    for (int n = 0; n < W + 4; n++) begin
      @(posedge clk);
      #1;
      if (done) dseen++;
    end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dseen); end
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    run_op(a, b, c, lat, r, co, da, rdy, ra);
    checks++; if ({co, r} !== model(a, b, c, 1'b0)) begin errors++; $display("FAIL abort_fresh_op: got %b_%h expected %h", co, r, model(a, b, c, 1'b0)); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat; logic [W-1:0] r, ra; logic co, da, rdy;
    sub_in = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, lat, r, co, da, rdy, ra);
    checks++; if ({co, r} !== 9'h10F) begin errors++; $display("FAIL sub_10_01: got %b_%h expected 1_0f", co, r); end
    run_op(8'h00, 8'h01, 1'b1, lat, r, co, da, rdy, ra);
    checks++; if ({co, r} !== 9'h0FF) begin errors++; $display("FAIL sub_00_01: got %b_%h expected 0_ff", co, r); end
    sub_in = 1'b0;
  endtask
`endif

  task automatic test_random();
    int lat; logic [W-1:0] r, ra, a, b; logic co, da, rdy, c, s;
    logic [W:0] exp_v;
    int bad_val, bad_lat;
    bad_val = 0; bad_lat = 0;
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom); s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
      sub_in = s;
`endif
      exp_v = model(a, b, c, s);
      run_op(a, b, c, lat, r, co, da, rdy, ra);
      checks++;
      if ({co, r} !== exp_v) begin
        errors++; bad_val++;
        if (bad_val <= 5) $display("FAIL random_op%0d: a=%h b=%h cin=%b sub=%b got %b_%h expected %h", i, a, b, c, s, co, r, exp_v);
      end
      checks++;
      if (lat !== W) begin
        errors++; bad_lat++;
        if (bad_lat <= 5) $display("FAIL random_latency%0d: got %0d expected %0d", i, lat, W);
      end
    end
`ifdef SERIAL_ADDER_SUB_EN
    sub_in = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
